// File: rtl/signed_fixed_point_div.sv
// Sequential signed fixed-point divider, O = A / B in Q(iD).(iF).
// Radix-2 restoring magnitude division, one quotient bit per clock,
// fixed N+1 cycle latency, start/valid handshake.
module signed_fixed_point_div #(
  parameter int unsigned iD = 16,
  parameter int unsigned iF = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [iD+iF-1:0]  A,
  input  logic [iD+iF-1:0]  B,
  output logic [iD+iF-1:0]  O,
  output logic              valid,
  output logic              busy,
  output logic              ovf,
  output logic              dz
);

  localparam int unsigned W  = iD + iF;
  localparam int unsigned N  = W + iF;
  localparam int unsigned CW = $clog2(N);

  localparam logic [W-1:0] sat_max = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] sat_min = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_d;

  logic          sign;
  logic          a_neg;
  logic          bz;
  logic [W-1:0]  bmag;
  logic [N-1:0]  dvd;
  logic [W-1:0]  rem;
  logic [N-1:0]  quo;
  logic [CW-1:0] cnt;

  logic [W-1:0]  a_mag_c;
  logic [W-1:0]  b_mag_c;
  logic [W:0]    rem_sh_c;
  logic [W:0]    diff_c;
  logic          ge_c;
  logic          pos_big_c;
  logic          neg_big_c;
  logic [W-1:0]  fin_o_c;
  logic          fin_ovf_c;

  // Operand magnitudes; the most negative value maps exactly to 2^(W-1).
  always_comb begin
    a_mag_c = A[W-1] ? W'(-A) : A;
    b_mag_c = B[W-1] ? W'(-B) : B;
  end

  // One restoring step: shift in the next dividend bit, trial-subtract |B|.
  always_comb begin
    rem_sh_c = {rem, dvd[N-1]};
    diff_c   = rem_sh_c - {1'b0, bmag};
    ge_c     = ~diff_c[W];
  end

  // Sign application, saturation and divide-by-zero forcing of the result.
  always_comb begin
    pos_big_c = |quo[N-1:W-1];
    neg_big_c = (|quo[N-1:W]) | (quo[W-1] & (|quo[W-2:0]));
    fin_ovf_c = 1'b0;
    fin_o_c   = sign ? W'(-quo[W-1:0]) : quo[W-1:0];
    if (bz) begin
      fin_o_c = a_neg ? sat_min : sat_max;
    end else if (!sign && pos_big_c) begin
      fin_o_c   = sat_max;
      fin_ovf_c = 1'b1;
    end else if (sign && neg_big_c) begin
      fin_o_c   = sat_min;
      fin_ovf_c = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic: IDLE -> DIV for N steps -> FIN -> IDLE.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = DIV;
      DIV:     if (cnt == '0) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accepted start and the per-cycle restoring iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign  <= 1'b0;
      a_neg <= 1'b0;
      bz    <= 1'b0;
      bmag  <= '0;
      dvd   <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign  <= A[W-1] ^ B[W-1];
            a_neg <= A[W-1];
            bz    <= (B == '0);
            bmag  <= b_mag_c;
            dvd   <= {a_mag_c, {iF{1'b0}}};
            rem   <= '0;
            quo   <= '0;
            cnt   <= CW'(N - 1);
          end
        end
        DIV: begin
          dvd <= {dvd[N-2:0], 1'b0};
          rem <= ge_c ? diff_c[W-1:0] : rem_sh_c[W-1:0];
          quo <= {quo[N-2:0], ge_c};
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered handshake and result outputs; result held until next FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      O     <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
      ovf   <= 1'b0;
      dz    <= 1'b0;
    end else begin
      valid <= (state == FIN);
      busy  <= (state_d != IDLE);
      if (state == FIN) begin
        O   <= fin_o_c;
        ovf <= fin_ovf_c;
        dz  <= bz;
      end
    end
  end

endmodule

// File: tb/tb_signed_fixed_point_div.sv
// Randomized and directed bench for signed_fixed_point_div against an
// arithmetic reference model of Q16.16 division.
module tb_signed_fixed_point_div;

  localparam int LAT = 49;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] dut_o;
  logic        dut_valid;
  logic        dut_busy;
  logic        dut_ovf;
  logic        dut_dz;

  signed_fixed_point_div #(.iD(16), .iF(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .O     (dut_o),
    .valid (dut_valid),
    .busy  (dut_busy),
    .ovf   (dut_ovf),
    .dz    (dut_dz)
  );

  typedef struct {
    int          acc;
    int          due;
    logic [31:0] o;
    logic        ovf;
    logic        dz;
  } exp_t;

  exp_t        q[$];
  int          tests;
  int          fails;
  int          cyc;
  logic [31:0] hold_o;
  logic        hold_ovf;
  logic        hold_dz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference: signed real-valued quotient scaled by 2^16, truncated toward zero.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] o, output logic ovf,
                                output logic dz);
    longint sa, sb, qv;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = 1'b0;
    dz  = 1'b0;
    if (sb == 0) begin
      dz = 1'b1;
      o  = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      qv = (sa * 65536) / sb;
      if (qv > 64'sd2147483647) begin
        o   = 32'h7FFF_FFFF;
        ovf = 1'b1;
      end else if (qv < -64'sd2147483648) begin
        o   = 32'h8000_0000;
        ovf = 1'b1;
      end else begin
        o = qv[31:0];
      end
    end
  endfunction

  // Cycle-by-cycle comparison of every output against the model's timeline.
  always @(negedge clk) begin : cmp
    logic ev, eb;
    if (!rst_n) begin
      tests++;
      if (dut_o !== 32'h0 || dut_valid !== 1'b0 || dut_busy !== 1'b0 ||
          dut_ovf !== 1'b0 || dut_dz !== 1'b0) begin
        fails++;
        $display("FAIL reset_state cyc=%0d: O=%h valid=%b busy=%b ovf=%b dz=%b, need all zero",
                 cyc, dut_o, dut_valid, dut_busy, dut_ovf, dut_dz);
      end
    end else begin
      ev = 1'b0;
      eb = 1'b0;
      for (int i = 0; i < q.size(); i++)
        if (cyc >= q[i].acc && cyc < q[i].due) eb = 1'b1;
      if (q.size() > 0 && q[0].due == cyc) begin
        ev       = 1'b1;
        hold_o   = q[0].o;
        hold_ovf = q[0].ovf;
        hold_dz  = q[0].dz;
        void'(q.pop_front());
      end
      tests++;
      if (dut_valid !== ev || dut_busy !== eb || dut_o !== hold_o ||
          dut_ovf !== hold_ovf || dut_dz !== hold_dz) begin
        fails++;
        $display("FAIL cycle_check cyc=%0d: got O=%h ovf=%b dz=%b valid=%b busy=%b, need O=%h ovf=%b dz=%b valid=%b busy=%b",
                 cyc, dut_o, dut_ovf, dut_dz, dut_valid, dut_busy,
                 hold_o, hold_ovf, hold_dz, ev, eb);
      end
    end
  end

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    model(a, b, e.o, e.ovf, e.dz);
    e.acc = cyc + 1;
    e.due = cyc + 1 + LAT;
    q.push_back(e);
  endtask

  // Present one accepted request for a single cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    push_exp(a, b);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL wait_done timeout: %0d results outstanding, need 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic pin(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eo, input logic eovf, input logic edz);
    logic [31:0] mo;
    logic        movf, mdz;
    model(a, b, mo, movf, mdz);
    tests++;
    if (mo !== eo || movf !== eovf || mdz !== edz) begin
      fails++;
      $display("FAIL pin_%s: model O=%h ovf=%b dz=%b, need O=%h ovf=%b dz=%b",
               name, mo, movf, mdz, eo, eovf, edz);
    end
    issue(a, b);
    wait_done();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] ra, rb, a2, b2;
    exp_t        e1;
    int          k;
    tests    = 0;
    fails    = 0;
    cyc      = 0;
    hold_o   = '0;
    hold_ovf = 1'b0;
    hold_dz  = 1'b0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a_in     = '0;
    b_in     = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    pin("exact",    32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0);
    pin("mixed",    32'hFFF8_8000, 32'h0002_8000, 32'hFFFD_0000, 1'b0, 1'b0);
    pin("third",    32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0);
    pin("negthird", 32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0);
    pin("bothneg",  32'hFFFF_0000, 32'hFFFD_0000, 32'h0000_5555, 1'b0, 1'b0);
    pin("ovfpos",   32'h7FFF_0000, 32'h0000_0100, 32'h7FFF_FFFF, 1'b1, 1'b0);
    pin("ovfneg",   32'h8000_0000, 32'h0000_8000, 32'h8000_0000, 1'b1, 1'b0);
    pin("minexact", 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0);
    pin("dzneg",    32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
    pin("dzpos",    32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
    pin("dzzero",   32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);

    // Starts while busy are ignored and operand changes do not leak in.
    issue(32'h0001_0000, 32'h0003_0000);
    repeat (4) @(negedge clk);
    start = 1'b1; a_in = $urandom; b_in = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start = 1'b1; a_in = $urandom; b_in = 32'h0;
    @(negedge clk);
    start = 1'b0; a_in = $urandom;
    wait_done();

    // Start held high through the valid cycle: back-to-back acceptance.
    @(negedge clk);
    start = 1'b1;
    a_in  = 32'hFFF8_8000;
    b_in  = 32'h0002_8000;
    push_exp(a_in, b_in);
    e1 = q[0];
    @(negedge clk);
    a2   = 32'h0003_0000;
    b2   = 32'hFFFE_0000;
    a_in = a2;
    b_in = b2;
    k    = 0;
    while (cyc < e1.due && k < 200) begin
      @(negedge clk);
      k++;
    end
    push_exp(a2, b2);
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Asynchronous reset in the middle of a division aborts it.
    issue(32'h0003_0000, 32'h0002_0000);
    repeat (29) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    q.delete();
    hold_o   = '0;
    hold_ovf = 1'b0;
    hold_dz  = 1'b0;
    tests++;
    if (dut_o !== 32'h0 || dut_busy !== 1'b0 || dut_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: O=%h busy=%b valid=%b, need 0 0 0",
               dut_o, dut_busy, dut_valid);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    issue(32'h0003_0000, 32'h0002_0000);
    wait_done();

    // Randomized operands across magnitude classes.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: ;
        1: begin
          rb = 32'($urandom_range(1, 65535));
          if ($urandom_range(0, 1) == 1) rb = -rb;
        end
        2: rb = 32'h0;
        3: ra = 32'h8000_0000;
        default: begin
          ra = 32'($signed(ra) >>> 12);
          rb = 32'($signed(rb) >>> 14);
        end
      endcase
      issue(ra, rb);
      wait_done();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
